// File: rtl/decision_tree_engine_core.sv
// Sequential decision-tree walker for CAN-bus intrusion detection.
// Fetches one node record per step over an external memory port and reports the leaf class.
module decision_tree_engine_core #(
    parameter int MAX_DEPTH   = 20,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [63:0] feature_00,
    input  logic [63:0] feature_01,
    input  logic [63:0] feature_10,
    output logic [8:0]  mem_addr,
    input  logic [8:0]  mem_node_id,
    input  logic [1:0]  mem_feature_idx,
    input  logic [63:0] mem_threshold,
    input  logic [8:0]  mem_left_child,
    input  logic [8:0]  mem_right_child,
    input  logic [1:0]  mem_prediction,
    input  logic        mem_is_leaf,
    input  logic        mem_data_valid,
    output logic [1:0]  result,
    output logic        is_attack,
    output logic [8:0]  final_node_id,
    output logic [8:0]  current_node,
    output logic [4:0]  tree_depth,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EVAL  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int         WCW       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);
    localparam logic [5:0] DEPTH_MAX = 6'(MAX_DEPTH);

    logic [63:0]    f00_r;
    logic [63:0]    f01_r;
    logic [63:0]    f10_r;
    logic [1:0]     idx_r;
    logic [63:0]    thr_r;
    logic [8:0]     left_r;
    logic [8:0]     right_r;
    logic [1:0]     pred_r;
    logic           leaf_r;
    logic [WCW-1:0] wait_cnt_r;

    logic [63:0]    sel_feature_s;
    logic           go_left_s;
    logic           accept_s;
    logic [5:0]     depth_next_s;
    logic [8:0]     child_s;

    // Split evaluation and record acceptance for the current step.
    always_comb begin
        sel_feature_s = 64'd0;
        case (idx_r)
            2'b00:   sel_feature_s = f00_r;
            2'b01:   sel_feature_s = f01_r;
            2'b10:   sel_feature_s = f10_r;
            default: sel_feature_s = 64'd0;
        endcase
        go_left_s    = ($signed(sel_feature_s) <= $signed(thr_r));
        child_s      = go_left_s ? left_r : right_r;
        // A record only counts if it answers the address we actually asked for.
        accept_s     = mem_data_valid && (mem_node_id == mem_addr);
        depth_next_s = {1'b0, tree_depth} + 6'd1;
    end

    // Walk FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            result        <= 2'b00;
            is_attack     <= 1'b0;
            final_node_id <= 9'd0;
            mem_addr      <= 9'd0;
            current_node  <= 9'd0;
            tree_depth    <= 5'd0;
            f00_r         <= 64'd0;
            f01_r         <= 64'd0;
            f10_r         <= 64'd0;
            idx_r         <= 2'b00;
            thr_r         <= 64'd0;
            left_r        <= 9'd0;
            right_r       <= 9'd0;
            pred_r        <= 2'b00;
            leaf_r        <= 1'b0;
            wait_cnt_r    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f00_r        <= feature_00;
                        f01_r        <= feature_01;
                        f10_r        <= feature_10;
                        current_node <= 9'd0;
                        mem_addr     <= 9'd0;
                        tree_depth   <= 5'd0;
                        busy         <= 1'b1;
                        state        <= S_FETCH;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_FETCH: begin
                    mem_addr   <= current_node;
                    wait_cnt_r <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (accept_s) begin
                        idx_r   <= mem_feature_idx;
                        thr_r   <= mem_threshold;
                        left_r  <= mem_left_child;
                        right_r <= mem_right_child;
                        pred_r  <= mem_prediction;
                        leaf_r  <= mem_is_leaf;
                        state   <= S_EVAL;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        result        <= 2'b11;
                        is_attack     <= 1'b1;
                        final_node_id <= current_node;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + {{(WCW-1){1'b0}}, 1'b1};
                    end
                end
                S_EVAL: begin
                    if (leaf_r) begin
                        result        <= pred_r;
                        is_attack     <= (pred_r != 2'b00);
                        final_node_id <= current_node;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end else if (depth_next_s > DEPTH_MAX) begin
                        result        <= 2'b11;
                        is_attack     <= 1'b1;
                        final_node_id <= current_node;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        // Present the child address now so a registered memory is ready by WAIT.
                        current_node <= child_s;
                        mem_addr     <= child_s;
                        tree_depth   <= depth_next_s[4:0];
                        state        <= S_FETCH;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decision_tree_engine_core.sv
// Randomized and directed bench for decision_tree_engine_core.
// A registered node memory feeds the DUT; a tree-walking reference model predicts each walk.
module tb_decision_tree_engine_core;

    localparam int MAX_DEPTH   = 20;
    localparam int MEM_TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [63:0] f00;
    logic [63:0] f01;
    logic [63:0] f10;
    logic [8:0]  mem_addr;
    logic [8:0]  mem_node_id;
    logic [1:0]  mem_feature_idx;
    logic [63:0] mem_threshold;
    logic [8:0]  mem_left_child;
    logic [8:0]  mem_right_child;
    logic [1:0]  mem_prediction;
    logic        mem_is_leaf;
    logic        mem_data_valid;
    logic [1:0]  result;
    logic        is_attack;
    logic [8:0]  final_node_id;
    logic [8:0]  current_node;
    logic [4:0]  tree_depth;
    logic [2:0]  state;

    int total;
    int bad;

    logic [1:0]         t_idx   [16];
    logic signed [63:0] t_thr   [16];
    logic [8:0]         t_left  [16];
    logic [8:0]         t_right [16];
    logic [1:0]         t_pred  [16];
    logic               t_leaf  [16];
    logic               mem_en;
    logic               mem_slow;
    logic [8:0]         addr_d;

    decision_tree_engine_core #(.MAX_DEPTH(MAX_DEPTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .feature_00(f00), .feature_01(f01), .feature_10(f10),
        .mem_addr(mem_addr), .mem_node_id(mem_node_id), .mem_feature_idx(mem_feature_idx),
        .mem_threshold(mem_threshold), .mem_left_child(mem_left_child),
        .mem_right_child(mem_right_child), .mem_prediction(mem_prediction),
        .mem_is_leaf(mem_is_leaf), .mem_data_valid(mem_data_valid),
        .result(result), .is_attack(is_attack), .final_node_id(final_node_id),
        .current_node(current_node), .tree_depth(tree_depth), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered node memory; slow mode answers the previous address for one extra cycle.
    always @(posedge clk) begin : mem_model
        logic [8:0] src;
        src = mem_slow ? addr_d : mem_addr;
        addr_d          <= mem_addr;
        mem_node_id     <= src;
        mem_feature_idx <= t_idx[src[3:0]];
        mem_threshold   <= t_thr[src[3:0]];
        mem_left_child  <= t_left[src[3:0]];
        mem_right_child <= t_right[src[3:0]];
        mem_prediction  <= t_pred[src[3:0]];
        mem_is_leaf     <= t_leaf[src[3:0]];
        mem_data_valid  <= mem_en;
    end

    task automatic clear_tree();
        for (int n = 0; n < 16; n++) begin
            t_idx[n] = 2'b00; t_thr[n] = 64'sd0; t_left[n] = 9'd0; t_right[n] = 9'd0;
            t_pred[n] = 2'b00; t_leaf[n] = 1'b1;
        end
    endtask

    task automatic set_internal(input int n, input logic [1:0] idx, input logic signed [63:0] thr,
                                input logic [8:0] l, input logic [8:0] r);
        t_leaf[n] = 1'b0; t_idx[n] = idx; t_thr[n] = thr; t_left[n] = l; t_right[n] = r;
    endtask

    task automatic set_leaf(input int n, input logic [1:0] p);
        t_leaf[n] = 1'b1; t_pred[n] = p;
    endtask

    task automatic basic_tree(input logic [1:0] idx, input logic signed [63:0] thr);
        clear_tree();
        set_internal(0, idx, thr, 9'd1, 9'd2);
        set_leaf(1, 2'b00);
        set_leaf(2, 2'b01);
    endtask

    // Reference: walk the tree from the root following the split rule directly.
    function automatic void ref_walk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                                     output logic [1:0] res, output logic [8:0] fin, output int evals);
        int node;
        int depth;
        logic signed [63:0] f;
        node = 0; depth = 0; evals = 0; res = 2'b11; fin = 9'd0;
        for (int step = 0; step < 64; step++) begin
            evals++;
            if (t_leaf[node]) begin res = t_pred[node]; fin = 9'(node); return; end
            if (depth + 1 > MAX_DEPTH) begin res = 2'b11; fin = 9'(node); return; end
            case (t_idx[node])
                2'd0:    f = a;
                2'd1:    f = b;
                2'd2:    f = c;
                default: f = 64'sd0;
            endcase
            node  = (f <= t_thr[node]) ? int'(t_left[node]) : int'(t_right[node]);
            depth = depth + 1;
        end
    endfunction

    // Pulse start at the current negedge; lat is the cycle count at which done is sampled.
    task automatic run_walk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                            input int max_cyc, output bit ok, output int lat, output bit busy_ok);
        f00 = a; f01 = b; f10 = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; ok = 1'b0; busy_ok = 1'b1;
        while (lat <= max_cyc) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                ok = 1'b1;
                if (busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
        end
        if (ok) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0d want=0", done); end
        total++; if (result !== 2'b00) begin bad++; $display("FAIL reset_result got=%0d want=0", result); end
        total++; if (is_attack !== 1'b0) begin bad++; $display("FAIL reset_attack got=%0d want=0", is_attack); end
        total++; if (final_node_id !== 9'd0) begin bad++; $display("FAIL reset_final got=%0d want=0", final_node_id); end
        total++; if (mem_addr !== 9'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
        total++; if (tree_depth !== 5'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", tree_depth); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic signed [63:0] fv [4];
        logic [1:0] er [4];
        logic [8:0] ef [4];
        bit ok; bit bok; int lat;
        fv[0] = 64'sd50 <<< 32;  er[0] = 2'b00; ef[0] = 9'd1;
        fv[1] = 64'sd200 <<< 32; er[1] = 2'b01; ef[1] = 9'd2;
        fv[2] = 64'sd100 <<< 32; er[2] = 2'b00; ef[2] = 9'd1;
        fv[3] = -(64'sd1 <<< 32); er[3] = 2'b00; ef[3] = 9'd1;
        basic_tree(2'b00, 64'sd100 <<< 32);
        for (int i = 0; i < 4; i++) begin
            run_walk(fv[i], 64'd0, 64'd0, 30, ok, lat, bok);
            total++; if (!ok) begin bad++; $display("FAIL basic_timeout case=%0d no done", i); end
            total++; if (lat != 7) begin bad++; $display("FAIL basic_latency case=%0d got=%0d want=7", i, lat); end
            total++; if (!bok) begin bad++; $display("FAIL basic_busy case=%0d busy profile wrong", i); end
            total++; if (result !== er[i]) begin bad++; $display("FAIL basic_result case=%0d got=%0d want=%0d", i, result, er[i]); end
            total++; if (is_attack !== (er[i] != 2'b00)) begin bad++; $display("FAIL basic_attack case=%0d got=%0d", i, is_attack); end
            total++; if (final_node_id !== ef[i]) begin bad++; $display("FAIL basic_final case=%0d got=%0d want=%0d", i, final_node_id, ef[i]); end
            total++; if (done !== 1'b0 || state !== 3'd0) begin bad++; $display("FAIL basic_pulse case=%0d done=%0d state=%0d want 0/0", i, done, state); end
        end
    endtask

    task automatic test_feature_sel();
        bit ok; bit bok; int lat;
        basic_tree(2'b01, 64'sd4 <<< 32);
        run_walk(64'd0, 64'sd8 <<< 32, 64'd0, 30, ok, lat, bok);
        total++; if (result !== 2'b01 || final_node_id !== 9'd2) begin bad++; $display("FAIL sel_idx01 got=%0d/%0d want=1/2", result, final_node_id); end
        basic_tree(2'b11, -64'sd1);
        run_walk(64'sd5, 64'sd5, 64'sd5, 30, ok, lat, bok);
        total++; if (result !== 2'b01) begin bad++; $display("FAIL sel_const_right got=%0d want=1", result); end
        basic_tree(2'b11, 64'sd0);
        run_walk(64'sd5, 64'sd5, 64'sd5, 30, ok, lat, bok);
        total++; if (result !== 2'b00) begin bad++; $display("FAIL sel_const_left got=%0d want=0", result); end
    endtask

    task automatic test_slow_valid();
        bit ok; bit bok; int lat;
        basic_tree(2'b01, 64'sd4 <<< 32);
        mem_en = 1'b0;
        fork
            run_walk(64'd0, 64'sd8 <<< 32, 64'd0, 60, ok, lat, bok);
            begin repeat (10) @(negedge clk); mem_en = 1'b1; end
        join
        total++; if (!ok || result !== 2'b01 || final_node_id !== 9'd2) begin bad++; $display("FAIL slow_valid ok=%0d got=%0d/%0d want=1/2", ok, result, final_node_id); end
        total++; if (lat <= 7) begin bad++; $display("FAIL slow_latency got=%0d want>7", lat); end
    endtask

    task automatic test_stale();
        bit ok; bit bok; int lat;
        basic_tree(2'b00, 64'sd100 <<< 32);
        mem_slow = 1'b1;
        run_walk(64'sd200 <<< 32, 64'd0, 64'd0, 40, ok, lat, bok);
        total++; if (!ok || result !== 2'b01 || final_node_id !== 9'd2) begin bad++; $display("FAIL stale_reject ok=%0d got=%0d/%0d want=1/2", ok, result, final_node_id); end
        mem_slow = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; bit bok; int lat;
        mem_en = 1'b0;
        run_walk(64'd0, 64'd0, 64'd0, 120, ok, lat, bok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_done no done within bound"); end
        total++; if (lat < MEM_TIMEOUT || lat > MEM_TIMEOUT + 3) begin bad++; $display("FAIL timeout_latency got=%0d want~%0d", lat, MEM_TIMEOUT); end
        total++; if (result !== 2'b11 || is_attack !== 1'b1) begin bad++; $display("FAIL timeout_result got=%0d/%0d want=3/1", result, is_attack); end
        mem_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cyclic();
        bit ok; bit bok; int lat;
        clear_tree();
        set_internal(0, 2'b00, 64'sd0, 9'd0, 9'd0);
        run_walk(64'd0, 64'd0, 64'd0, 120, ok, lat, bok);
        total++; if (!ok || result !== 2'b11 || final_node_id !== 9'd0) begin bad++; $display("FAIL cyclic_abort ok=%0d got=%0d/%0d want=3/0", ok, result, final_node_id); end
        total++; if (lat != 3 * (MAX_DEPTH + 1) + 1) begin bad++; $display("FAIL cyclic_latency got=%0d want=%0d", lat, 3 * (MAX_DEPTH + 1) + 1); end
        total++; if (tree_depth !== 5'(MAX_DEPTH)) begin bad++; $display("FAIL cyclic_depth got=%0d want=%0d", tree_depth, MAX_DEPTH); end
    endtask

    task automatic test_rst_mid();
        int dones;
        basic_tree(2'b00, 64'sd100 <<< 32);
        mem_en = 1'b0;
        f00 = 64'sd200 <<< 32;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++; if (state !== 3'd2) begin bad++; $display("FAIL rst_pre_wait state got=%0d want=2", state); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if (busy !== 1'b0 || state !== 3'd0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid busy=%0d state=%0d done=%0d want 0/0/0", busy, state, done); end
        total++; if (result !== 2'b00 || final_node_id !== 9'd0 || mem_addr !== 9'd0) begin bad++; $display("FAIL rst_mid_outputs result=%0d final=%0d addr=%0d want 0", result, final_node_id, mem_addr); end
        mem_en = 1'b1;
        dones = 0;
        repeat (10) begin @(negedge clk); if (done === 1'b1) dones++; end
        total++; if (dones != 0) begin bad++; $display("FAIL rst_no_done got=%0d pulses want=0", dones); end
    endtask

    task automatic test_start_busy();
        bit ok; bit bok; int lat; int dones;
        basic_tree(2'b00, 64'sd100 <<< 32);
        fork
            run_walk(64'sd50 <<< 32, 64'd0, 64'd0, 30, ok, lat, bok);
            begin
                repeat (2) @(negedge clk);
                f00 = 64'sd200 <<< 32; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        total++; if (!ok || result !== 2'b00 || final_node_id !== 9'd1 || lat != 7) begin bad++; $display("FAIL busy_start ok=%0d got=%0d/%0d lat=%0d want=0/1/7", ok, result, final_node_id, lat); end
        dones = 0;
        repeat (10) begin @(negedge clk); if (done === 1'b1) dones++; end
        total++; if (dones != 0) begin bad++; $display("FAIL busy_start_extra got=%0d pulses want=0", dones); end
    endtask

    task automatic test_random();
        bit ok; bit bok; int lat; int ev;
        logic [1:0] er; logic [8:0] ef;
        logic signed [63:0] a, b, c, th;
        int r;
        for (int it = 0; it < 24; it++) begin
            clear_tree();
            for (int n = 0; n < 3; n++) begin
                r = int'($urandom_range(0, 400)) - 200; th = r;
                set_internal(n, 2'($urandom_range(0, 3)), th, 9'(2 * n + 1), 9'(2 * n + 2));
            end
            for (int n = 3; n < 7; n++) set_leaf(n, 2'($urandom_range(0, 2)));
            if ($urandom_range(0, 3) == 0) set_leaf(1, 2'($urandom_range(0, 2)));
            r = int'($urandom_range(0, 500)) - 250; a = r;
            r = int'($urandom_range(0, 500)) - 250; b = r;
            r = int'($urandom_range(0, 500)) - 250; c = r;
            ref_walk(a, b, c, er, ef, ev);
            run_walk(a, b, c, 40, ok, lat, bok);
            total++; if (!ok) begin bad++; $display("FAIL rand_timeout it=%0d no done", it); end
            total++; if (result !== er || is_attack !== (er != 2'b00)) begin bad++; $display("FAIL rand_result it=%0d got=%0d/%0d want=%0d", it, result, is_attack, er); end
            total++; if (final_node_id !== ef) begin bad++; $display("FAIL rand_final it=%0d got=%0d want=%0d", it, final_node_id, ef); end
            total++; if (lat != 3 * ev + 1) begin bad++; $display("FAIL rand_latency it=%0d got=%0d want=%0d", it, lat, 3 * ev + 1); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; f00 = 64'd0; f01 = 64'd0; f10 = 64'd0;
        mem_en = 1'b1; mem_slow = 1'b0;
        clear_tree();
        @(negedge clk);
        test_reset();
        test_basic();
        test_feature_sel();
        test_slow_valid();
        test_stale();
        test_timeout();
        test_cyclic();
        test_rst_mid();
        test_start_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decision_tree_engine_core.md
# decision_tree_engine_core

Sequential inference engine for the CAN-bus intrusion-detection decision tree. On a start pulse it latches three Q32.32 feature words, walks the tree one node at a time from the root by fetching node records over an external node-memory port, and reports the leaf's class (normal/attack). It sits between the feature extractor and the alarm/logging logic.

## Interface
- MAX_DEPTH, 20: maximum number of internal nodes visited before the walk aborts with an error.
- MEM_TIMEOUT, 64: maximum cycles spent waiting for one node record before the walk aborts with an error.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high while a walk is in progress.
- done  out  1  one-cycle pulse when result outputs are updated.
- feature_00 / feature_01 / feature_10  in  64 each  CAN ID / DLC / data-timestamp, signed Q32.32.
- mem_addr  out  9  node index requested.
- mem_node_id  in  9  index of the node record being presented.
- mem_feature_idx  in  2  feature selector for the split.
- mem_threshold  in  64  signed Q32.32 split threshold.
- mem_left_child / mem_right_child  in  9 each  child node indices.
- mem_prediction  in  2  leaf class (00 normal, 01 attack, others reserved).
- mem_is_leaf  in  1  record is a leaf.
- mem_data_valid  in  1  record fields are valid this cycle.
- result  out  2  final class; 2'b11 is the error code.
- is_attack  out  1  result != 2'b00.
- final_node_id  out  9  node index at which the walk ended.
- current_node  out  9  debug: node being processed.
- tree_depth  out  5  debug: internal nodes evaluated in the current walk.
- state  out  3  debug: FSM encoding.

## Operation
- FSM states/encoding: IDLE=0, FETCH=1, WAIT=2, EVAL=3, DONE=4.
- IDLE: on start=1, latch all three features, current_node<=0, tree_depth<=0, go to FETCH. start in any other state is ignored.
- FETCH: mem_addr<=current_node (registered output); clear wait counter; go to WAIT.
- WAIT: accept record when mem_data_valid=1 AND mem_node_id==mem_addr (stale data is rejected); capture all fields, go to EVAL. Wait counter reaching MEM_TIMEOUT -> result<=2'b11, final_node_id<=current_node, go to DONE.
- EVAL, leaf: result<=mem_prediction, final_node_id<=current_node, go to DONE.
- EVAL, internal: select feature by idx (00->feature_00, 01->feature_01, 10->feature_10, 11->constant 0). Signed 64-bit compare: feature <= threshold -> left child, else right child. current_node<=child, tree_depth+1, go to FETCH. If tree_depth+1 exceeds MAX_DEPTH -> result<=2'b11, final_node_id<=current_node, go to DONE.
- DONE: done=1 for this one cycle; go to IDLE.
- result, is_attack, final_node_id hold their value until the next walk completes.

## Timing
- Reset values: busy=0, done=0, result=0, is_attack=0, final_node_id=0, mem_addr=0, current_node=0, tree_depth=0, state=IDLE.
- busy=1 in FETCH, WAIT, EVAL; 0 in IDLE and DONE.
- With a memory that registers the record one cycle after mem_addr changes: each node costs 3 cycles (FETCH, WAIT, EVAL). start at cycle t, root -> leaf (two nodes) -> done at t+7.
- Next start accepted the cycle after done (back in IDLE).
- Feature input changes after start is sampled do not affect the walk in progress.
- rst during a walk: return to IDLE next edge, all outputs to reset values, no done pulse.

## Test plan
- Root (node 0: idx 00, threshold 100, children 1/2); leaf 1 pred 00, leaf 2 pred 01. feature_00=50 -> done at t+7, result=00, is_attack=0, final_node_id=1.
- Same tree, feature_00=200 -> result=01, is_attack=1, final_node_id=2.
- Boundary: feature_00=100 -> left (result=00, node 1). feature_00=-1 (signed Q32.32) -> left.
- Root idx 01 with threshold 4, feature_01=8 -> right, result=01. Hold mem_data_valid low 10 cycles -> walk completes correctly with longer latency.
- Memory never valid -> after MEM_TIMEOUT cycles, done pulses, result=11, is_attack=1. Cyclic tree (child points to 0) -> abort with result=11 after MAX_DEPTH.
- Assert rst mid-WAIT -> busy=0, state=IDLE, no done pulse. start while busy is ignored.
